// File: rtl/serial_nibble_deserializer_pkg.sv
// serial_nibble_deserializer_pkg: shared FSM states and default frame shape
package serial_nibble_deserializer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    localparam int DEF_DATA_W    = 4;
    localparam int DEF_PARITY_EN = 1;

endpackage

// File: rtl/serial_nibble_deserializer.sv
// serial_nibble_deserializer: framed LSB-first serial receiver that emits one load pulse per good frame
module serial_nibble_deserializer
    import serial_nibble_deserializer_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int PARITY_EN = DEF_PARITY_EN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_en,
    input  logic              rx_bit,
    output logic [DATA_W-1:0] word_out,
    output logic              word_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    // Counter is at least one bit wide so DATA_W=1 still elaborates
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                par_bad_q, par_bad_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic                valid_q, valid_d;
    logic                perr_q, perr_d;
    logic                ferr_q, ferr_d;
    logic                busy_q, busy_d;

    // Next-state and frame assembly; everything advances only on a sample strobe
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        par_bad_d = par_bad_q;
        word_d    = word_q;
        valid_d   = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        if (sample_en) begin
            case (state_q)
                IDLE: begin
                    if (!rx_bit) begin
                        state_d   = DATA;
                        cnt_d     = '0;
                        par_bad_d = 1'b0;
                    end
                end
                DATA: begin
                    shift_d         = shift_q >> 1;
                    shift_d[DATA_W-1] = rx_bit;
                    if (cnt_q == CNT_W'(DATA_W - 1))
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    else
                        cnt_d = cnt_q + 1'b1;
                end
                PARITY: begin
                    par_bad_d = (^shift_q) ^ rx_bit;
                    state_d   = STOP;
                end
                STOP: begin
                    if (rx_bit) begin
                        state_d = IDLE;
                        if (par_bad_q) begin
                            perr_d = 1'b1;
                        end else begin
                            word_d  = shift_q;
                            valid_d = 1'b1;
                        end
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end
                BREAK: begin
                    if (rx_bit)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            par_bad_q <= 1'b0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            par_bad_q <= par_bad_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
        end
    end

    assign word_out   = word_q;
    assign word_valid = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_serial_nibble_deserializer.sv
// tb_serial_nibble_deserializer: directed frames with a scoreboard of expected pulses
module tb_serial_nibble_deserializer;

    typedef struct {
        int          kind;
        logic [15:0] word;
        int          cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sample_en = 1'b0;
    logic       rx_bit = 1'b1;
    logic       rx8 = 1'b1;
    logic [3:0] word_out;
    logic       word_valid, parity_err, frame_err, busy;
    logic [7:0] word8;
    logic       valid8, perr8, ferr8, busy8;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         gap = 1;
    logic [3:0] last_good = '0;
    exp_t       q4[$];
    exp_t       q8[$];

    serial_nibble_deserializer dut4 (
        .clk(clk), .reset(reset), .sample_en(sample_en), .rx_bit(rx_bit),
        .word_out(word_out), .word_valid(word_valid), .parity_err(parity_err),
        .frame_err(frame_err), .busy(busy)
    );

    serial_nibble_deserializer #(.DATA_W(8), .PARITY_EN(0)) dut8 (
        .clk(clk), .reset(reset), .sample_en(sample_en), .rx_bit(rx8),
        .word_out(word8), .word_valid(valid8), .parity_err(perr8),
        .frame_err(ferr8), .busy(busy8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulses are compared against the scoreboard on the falling edge after they appear
    always @(negedge clk) begin
        if (!reset && (word_valid || parity_err || frame_err)) begin
            chk("onehot_pulse4", 32'($onehot0({word_valid, parity_err, frame_err})), 32'd1);
            if (q4.size() == 0) begin
                chk("unexpected_pulse4", {word_valid, parity_err, frame_err}, 32'd0);
            end else begin
                exp_t e;
                e = q4.pop_front();
                chk("kind4", word_valid ? 32'd0 : parity_err ? 32'd1 : 32'd2, 32'(e.kind));
                chk("word4", 32'(word_out), 32'(e.word));
                chk("latency4", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && (valid8 || perr8 || ferr8)) begin
            if (q8.size() == 0) begin
                chk("unexpected_pulse8", {valid8, perr8, ferr8}, 32'd0);
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk("kind8", valid8 ? 32'd0 : perr8 ? 32'd1 : 32'd2, 32'(e.kind));
                chk("word8", 32'(word8), 32'(e.word));
                chk("latency8", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // One sample on each line, then gap-1 strobe-free cycles; returns 1 time unit after a rising edge
    task automatic drive(input logic b, input logic b8);
        @(negedge clk);
        rx_bit = b;
        rx8 = b8;
        sample_en = 1'b1;
        @(posedge clk);
        #1;
        sample_en = 1'b0;
        repeat (gap - 1) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [3:0] d, input logic par, input logic stop);
        exp_t e;
        drive(1'b0, 1'b1);
        chk("busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) drive(d[i], 1'b1);
        drive(par, 1'b1);
        e.cyc = cyc + 1;
        if (!stop) e.kind = 2;
        else if (par != ^d) e.kind = 1;
        else begin
            e.kind = 0;
            last_good = d;
        end
        e.word = 16'(last_good);
        q4.push_back(e);
        drive(stop, 1'b1);
    endtask

    task automatic send_frame8(input logic [7:0] d);
        exp_t e;
        drive(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) drive(1'b1, d[i]);
        e.cyc = cyc + 1;
        e.kind = 0;
        e.word = 16'(d);
        q8.push_back(e);
        drive(1'b1, 1'b1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_word", 32'(word_out), 32'd0);
        chk("rst_valid", 32'(word_valid), 32'd0);
        chk("rst_perr", 32'(parity_err), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        gap = 1;
        send_frame(4'b1101, 1'b1, 1'b1);
        drive(1'b1, 1'b1);
        chk("word_1101", 32'(word_out), 32'hd);

        gap = 4;
        send_frame(4'b1101, 1'b1, 1'b1);
        drive(1'b1, 1'b1);
        chk("word_1101_slow", 32'(word_out), 32'hd);
        chk("busy_idle_slow", 32'(busy), 32'd0);

        gap = 1;
        send_frame(4'b0011, 1'b1, 1'b1);
        drive(1'b1, 1'b1);
        chk("word_kept_perr", 32'(word_out), 32'hd);

        send_frame(4'b0101, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1);
            chk("busy_break", 32'(busy), 32'd1);
        end
        drive(1'b1, 1'b1);
        chk("busy_break_exit", 32'(busy), 32'd0);
        send_frame(4'b1010, 1'b0, 1'b1);
        drive(1'b1, 1'b1);
        chk("word_1010", 32'(word_out), 32'ha);

        drive(1'b0, 1'b1);
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_word", 32'(word_out), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_valid", 32'(word_valid), 32'd0);
        last_good = '0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        send_frame(4'b0110, 1'b0, 1'b1);
        drive(1'b1, 1'b1);
        chk("word_0110", 32'(word_out), 32'h6);

        send_frame(4'b1111, 1'b0, 1'b1);
        send_frame(4'b0001, 1'b1, 1'b1);
        drive(1'b1, 1'b1);
        chk("word_0001", 32'(word_out), 32'h1);

        send_frame8(8'ha5);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        chk("word8_a5", 32'(word8), 32'ha5);
        chk("word4_unchanged", 32'(word_out), 32'h1);
        chk("sb4_empty", 32'(q4.size()), 32'd0);
        chk("sb8_empty", 32'(q8.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
